// File: rtl/bundle_threshold_decoder_if.sv
// Port bundle between the bundle source and bundle_threshold_decoder.
// The master drives samples and clear; the slave (decoder) returns decisions and statistics.
interface bundle_threshold_decoder_if #(
  parameter int N      = 10,
  parameter int WINDOW = 16
);
  localparam int CW = $clog2(WINDOW + 1);

  logic [N-1:0]  bundle_i;
  logic          valid_i;
  logic          clear_i;
  logic          decision_o;
  logic          ambiguous_o;
  logic          result_valid_o;
  logic [CW-1:0] ones_cnt_o;
  logic [CW-1:0] zeros_cnt_o;
  logic [CW-1:0] undef_cnt_o;
  logic [15:0]   amb_total_o;

  modport master (
    output bundle_i, valid_i, clear_i,
    input  decision_o, ambiguous_o, result_valid_o,
    input  ones_cnt_o, zeros_cnt_o, undef_cnt_o, amb_total_o
  );

  modport slave (
    input  bundle_i, valid_i, clear_i,
    output decision_o, ambiguous_o, result_valid_o,
    output ones_cnt_o, zeros_cnt_o, undef_cnt_o, amb_total_o
  );
endinterface

// File: rtl/bundle_threshold_decoder.sv
// Classifies bundle samples by popcount and decides one logical bit per WINDOW samples.
// Define DECODER_STATS_EN to build the per-window counts and the saturating ambiguous total.
module bundle_threshold_decoder #(
  parameter int N         = 10,
  parameter int HI_THRESH = 8,
  parameter int LO_THRESH = 2,
  parameter int WINDOW    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  bundle_threshold_decoder_if.slave bus
);
  localparam int CW = $clog2(WINDOW + 1);
  localparam int PW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  typedef enum logic [1:0] {CLS_ZERO, CLS_ONE, CLS_AMB} cls_t;

  state_t        state;
  logic          s1_valid;
  logic [N-1:0]  s1_bundle;
  logic          s2_valid;
  cls_t          s2_cls;
  logic [PW-1:0] s2_pop;
  logic [PW-1:0] pop;
  cls_t          cls;
  logic [CW-1:0] ones_acc, zeros_acc, win_cnt;
  logic [CW-1:0] ones_next, zeros_next, win_next;
  logic          one_wins, zero_wins;
  logic          decision, ambiguous, result_valid;

  always_comb begin
    pop = '0;
    for (int k = 0; k < N; k++) pop = pop + PW'(s1_bundle[k]);
    if (pop >= PW'(HI_THRESH))      cls = CLS_ONE;
    else if (pop <= PW'(LO_THRESH)) cls = CLS_ZERO;
    else                            cls = CLS_AMB;
  end

  // A REPORT cycle restarts the window, so a sample landing then becomes sample 1 of the next one.
  always_comb begin
    ones_next  = (state == REPORT) ? '0 : ones_acc;
    zeros_next = (state == REPORT) ? '0 : zeros_acc;
    win_next   = (state == REPORT) ? '0 : win_cnt;
    if (s2_valid) begin
      win_next = win_next + CW'(1);
      if (s2_cls == CLS_ONE)  ones_next  = ones_next + CW'(1);
      if (s2_cls == CLS_ZERO) zeros_next = zeros_next + CW'(1);
    end
  end

  assign one_wins  = (ones_acc > zeros_acc) && ({ones_acc, 1'b0} >= (CW+1)'(WINDOW));
  assign zero_wins = (zeros_acc > ones_acc) && ({zeros_acc, 1'b0} >= (CW+1)'(WINDOW));

`ifdef DECODER_STATS_EN
  logic [CW-1:0] undef_acc, undef_next;
  logic [CW-1:0] ones_cnt, zeros_cnt, undef_cnt;
  logic [15:0]   amb_total;
  logic [16:0]   amb_sum;

  always_comb begin
    undef_next = (state == REPORT) ? '0 : undef_acc;
    if (s2_valid && s2_cls == CLS_AMB) undef_next = undef_next + CW'(1);
  end

  assign amb_sum = {1'b0, amb_total} + 17'(undef_acc);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n || bus.clear_i) begin
      state        <= IDLE;
      s1_valid     <= 1'b0;
      s1_bundle    <= '0;
      s2_valid     <= 1'b0;
      s2_cls       <= CLS_ZERO;
      s2_pop       <= '0;
      ones_acc     <= '0;
      zeros_acc    <= '0;
      win_cnt      <= '0;
      result_valid <= 1'b0;
`ifdef DECODER_STATS_EN
      undef_acc    <= '0;
      amb_total    <= '0;
`endif
      // Clear keeps the last decision and counts visible; only reset wipes them.
      if (!reset_n) begin
        decision  <= 1'b0;
        ambiguous <= 1'b0;
`ifdef DECODER_STATS_EN
        ones_cnt  <= '0;
        zeros_cnt <= '0;
        undef_cnt <= '0;
`endif
      end
    end else begin
      s1_valid     <= bus.valid_i;
      s1_bundle    <= bus.bundle_i;
      s2_valid     <= s1_valid;
      s2_cls       <= cls;
      s2_pop       <= pop;
      ones_acc     <= ones_next;
      zeros_acc    <= zeros_next;
      win_cnt      <= win_next;
      result_valid <= (state == REPORT);
`ifdef DECODER_STATS_EN
      undef_acc    <= undef_next;
`endif
      if (state == REPORT) begin
        if (one_wins) begin
          decision  <= 1'b1;
          ambiguous <= 1'b0;
        end else if (zero_wins) begin
          decision  <= 1'b0;
          ambiguous <= 1'b0;
        end else begin
          ambiguous <= 1'b1;
        end
`ifdef DECODER_STATS_EN
        ones_cnt  <= ones_acc;
        zeros_cnt <= zeros_acc;
        undef_cnt <= undef_acc;
        amb_total <= amb_sum[16] ? 16'hFFFF : amb_sum[15:0];
`endif
      end
      if (win_next == CW'(WINDOW))          state <= REPORT;
      else if (s2_valid || state == REPORT) state <= ACCUM;
    end
  end

  assign bus.decision_o     = decision;
  assign bus.ambiguous_o    = ambiguous;
  assign bus.result_valid_o = result_valid;
`ifdef DECODER_STATS_EN
  assign bus.ones_cnt_o     = ones_cnt;
  assign bus.zeros_cnt_o    = zeros_cnt;
  assign bus.undef_cnt_o    = undef_cnt;
  assign bus.amb_total_o    = amb_total;
`else
  assign bus.ones_cnt_o     = '0;
  assign bus.zeros_cnt_o    = '0;
  assign bus.undef_cnt_o    = '0;
  assign bus.amb_total_o    = '0;
`endif

  // The registered popcount is kept for debug visibility alongside the class.
  logic unused_pop;
  assign unused_pop = ^s2_pop;
endmodule

// File: tb/tb_bundle_threshold_decoder.sv
// Randomized and directed bench for bundle_threshold_decoder, checked against a window-level
// reference model that tracks accepted samples and schedules each expected result.
module tb_bundle_threshold_decoder;
  localparam int N      = 10;
  localparam int HI     = 8;
  localparam int LO     = 2;
  localparam int WINDOW = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bundle_threshold_decoder_if #(.N(N), .WINDOW(WINDOW)) bus ();

  bundle_threshold_decoder #(
    .N(N), .HI_THRESH(HI), .LO_THRESH(LO), .WINDOW(WINDOW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    int due;
    bit decided;
    bit dec;
    int ones;
    int zeros;
    int undef;
  } ev_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   win_q[$];
  ev_t  pend[$];
  bit   exp_strobe, exp_dec, exp_amb;
  int   exp_ones, exp_zeros, exp_undef, exp_total;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", tag, observed, expected, cyc);
    end
  endtask

  function automatic int classify(input logic [N-1:0] b);
    int p;
    p = $countones(b);
    if (p >= HI) return 1;
    if (p <= LO) return 0;
    return 2;
  endfunction

  // Window-level model: completed windows are scored and due three edges after the last accept.
  task automatic modelEdge(input bit v, input logic [N-1:0] b, input bit clr, input bit rst);
    ev_t ev;
    exp_strobe = 1'b0;
    if (rst) begin
      win_q.delete(); pend.delete();
      exp_dec = 0; exp_amb = 0; exp_ones = 0; exp_zeros = 0; exp_undef = 0; exp_total = 0;
      return;
    end
    if (clr) begin
      win_q.delete(); pend.delete();
      exp_total = 0;
      return;
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = pend.pop_front();
      exp_strobe = 1'b1;
      if (ev.decided) exp_dec = ev.dec;
      exp_amb   = !ev.decided;
      exp_ones  = ev.ones;
      exp_zeros = ev.zeros;
      exp_undef = ev.undef;
      exp_total = (exp_total + ev.undef > 65535) ? 65535 : exp_total + ev.undef;
    end
    if (v) begin
      win_q.push_back(classify(b));
      if (win_q.size() == WINDOW) begin
        ev.due = cyc + 3; ev.ones = 0; ev.zeros = 0; ev.undef = 0;
        foreach (win_q[i]) begin
          if (win_q[i] == 1)      ev.ones++;
          else if (win_q[i] == 0) ev.zeros++;
          else                    ev.undef++;
        end
        ev.decided = 1'b1;
        if (ev.ones > ev.zeros && 2 * ev.ones >= WINDOW)       ev.dec = 1'b1;
        else if (ev.zeros > ev.ones && 2 * ev.zeros >= WINDOW) ev.dec = 1'b0;
        else begin ev.decided = 1'b0; ev.dec = 1'b0; end
        pend.push_back(ev);
        win_q.delete();
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("strobe", 32'(bus.result_valid_o), 32'(exp_strobe));
    checkOutput("decision", 32'(bus.decision_o), 32'(exp_dec));
    checkOutput("ambiguous", 32'(bus.ambiguous_o), 32'(exp_amb));
`ifdef DECODER_STATS_EN
    checkOutput("ones_cnt", 32'(bus.ones_cnt_o), 32'(exp_ones));
    checkOutput("zeros_cnt", 32'(bus.zeros_cnt_o), 32'(exp_zeros));
    checkOutput("undef_cnt", 32'(bus.undef_cnt_o), 32'(exp_undef));
    checkOutput("amb_total", 32'(bus.amb_total_o), 32'(exp_total));
`else
    checkOutput("ones_cnt_off", 32'(bus.ones_cnt_o), 32'd0);
    checkOutput("zeros_cnt_off", 32'(bus.zeros_cnt_o), 32'd0);
    checkOutput("undef_cnt_off", 32'(bus.undef_cnt_o), 32'd0);
    checkOutput("amb_total_off", 32'(bus.amb_total_o), 32'd0);
`endif
  endtask

  task automatic applyStimulus(input bit v, input logic [N-1:0] b, input bit clr, input bit rst);
    @(negedge clk);
    bus.valid_i  = v;
    bus.bundle_i = b;
    bus.clear_i  = clr;
    reset_n      = ~rst;
    @(posedge clk);
    cyc++;
    modelEdge(v, b, clr, rst);
    #1;
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] b;
    int r;
    bus.valid_i = 1'b0; bus.bundle_i = '0; bus.clear_i = 1'b0; reset_n = 1'b0;

    repeat (3) applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0);
    idle(2);
    checkOutput("all_ones_early", 32'(bus.result_valid_o), 32'd0);
    idle(1);
    checkOutput("all_ones_strobe", 32'(bus.result_valid_o), 32'd1);
    checkOutput("all_ones_dec", 32'(bus.decision_o), 32'd1);
    idle(2);

    applyStimulus(1'b1, 10'h000, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h001, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h003, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h000, 1'b0, 1'b0);
    idle(4);
    repeat (4) applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b1, 10'h01F, 1'b0, 1'b0);
    idle(5);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0);
      idle(1 + (i % 3));
    end
    repeat (14) applyStimulus(1'b1, (cyc % 3 == 0) ? 10'h000 : 10'h3FF, 1'b0, 1'b0);
    idle(5);

    repeat (2) applyStimulus(1'b1, 10'h000, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h000, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0);
    idle(6);

    repeat (3) applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h3FF, 1'b1, 1'b0);
    idle(5);
    repeat (4) applyStimulus(1'b1, 10'h000, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(5);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 199);
      case ($urandom_range(0, 2))
        0:       b = N'(~($urandom & $urandom & $urandom));
        1:       b = N'($urandom & $urandom & $urandom);
        default: b = N'($urandom);
      endcase
      applyStimulus(r < 140, b, r >= 196, r == 195);
    end
    idle(5);

`ifdef DECODER_STATS_EN
    applyStimulus(1'b1, 10'h000, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0);
    for (int w = 0; w < 16384; w++) repeat (4) applyStimulus(1'b1, 10'h01F, 1'b0, 1'b0);
    idle(5);
    checkOutput("amb_saturated", 32'(bus.amb_total_o), 32'hFFFF);
    checkOutput("amb_sat_dec_held", 32'(bus.decision_o), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("amb_cleared", 32'(bus.amb_total_o), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bundle_threshold_decoder.md
# bundle_threshold_decoder

Downstream consumer of the `multiplexing_unit` output bundle. Each N-bit bundle sample is classified by population count:
- logical 1 if at least HI_THRESH wires are high;
- logical 0 if at most LO_THRESH wires are high;
- ambiguous otherwise.

Classifications accumulate over a window of WINDOW accepted samples, and the block emits one decided bit per window with a one-cycle result strobe. It is the measurement end of the restoring chain: it turns the noisy bundle into a logical value plus error statistics.

## Interface
- N, 10, bundle width; must match the upstream unit.
- HI_THRESH, 8, minimum popcount classified as logical 1; LO_THRESH < HI_THRESH <= N.
- LO_THRESH, 2, maximum popcount classified as logical 0.
- WINDOW, 16, accepted samples per decision; >= 1.
- clk  input  1  clock.
- reset_n  input  1  reset, synchronous, active-low.
- bundle_i  input  N  bundle from upstream z_o.
- valid_i  input  1  bundle_i is valid this cycle (upstream valid_o).
- clear_i  input  1  synchronous window restart.
- decision_o  output  1  last decided logical value.
- ambiguous_o  output  1  last window produced no decision.
- result_valid_o  output  1  one-cycle strobe: decision_o, ambiguous_o and the counts are updated.
- ones_cnt_o  output  $clog2(WINDOW+1)  samples classified 1 in the last window.
- zeros_cnt_o  output  $clog2(WINDOW+1)  samples classified 0 in the last window.
- undef_cnt_o  output  $clog2(WINDOW+1)  samples classified ambiguous in the last window.
- amb_total_o  output  16  running ambiguous-sample total; saturating.

## Operation
- Pipeline:
  - S1 registers bundle_i and valid_i.
  - S2 registers the popcount (width $clog2(N+1)) and a 2-bit class: ONE, ZERO or AMB.
  - S3 holds the window accumulators (ones_acc, zeros_acc, undef_acc) and the sample counter win_cnt.
- Only valid samples enter S3. Bubbles (valid_i=0) flow through with the valid bit low and change nothing.
- FSM states:
  - IDLE: after reset or clear_i. Moves to ACCUM on the first valid sample reaching S3.
  - ACCUM: increments the accumulator for each valid S3 input and increments win_cnt.
  - REPORT: entered when win_cnt reaches WINDOW; lasts one cycle. Returns to ACCUM.
- Window boundary behaviour:
  - The REPORT cycle registers the results and clears the accumulators and win_cnt.
  - A valid sample arriving at S3 during REPORT counts as sample 1 of the next window. No sample is ever dropped at a window boundary.
- Decision rule, evaluated on the completed window:
  - If ones_acc > zeros_acc and 2*ones_acc >= WINDOW: decision_o=1.
  - Else if zeros_acc > ones_acc and 2*zeros_acc >= WINDOW: decision_o=0.
  - Otherwise: ambiguous_o=1 and decision_o holds its previous value.
- ones_cnt_o, zeros_cnt_o and undef_cnt_o take the final accumulator values and are held until the next REPORT.
- amb_total_o adds undef_acc at each REPORT and saturates at 16'hFFFF. It is cleared only by reset or clear_i.
- clear_i:
  - Flushes the S1/S2 valid bits and the accumulators, and clears win_cnt and amb_total_o.
  - Moves the FSM to IDLE.
  - decision_o, ambiguous_o and the window counts hold.
  - clear_i together with valid_i: clear wins and the sample is discarded.
- Reset: all outputs 0, FSM in IDLE, pipeline valid bits 0.

## Timing
- A sample is accepted at edge E0 into S1, classified at E1 and accumulated at E2.
- If that sample is the WINDOW-th, the REPORT registers update at E3. result_valid_o is high for exactly the cycle after E3.
- Latency from the last accept to the strobe is 3 cycles; the strobe is never high two cycles in a row.
- With continuous valid_i, strobes are exactly WINDOW cycles apart.
- clear_i asserted at edge C takes effect at C. No strobe occurs from pre-clear samples, including a REPORT that would have fired at C+1.
- Reset mid-window behaves as clear_i and also zeroes all outputs.

## Configuration
- DECODER_STATS_EN defined: ones_cnt_o, zeros_cnt_o, undef_cnt_o and amb_total_o are live as described.
- DECODER_STATS_EN undefined:
  - Those four outputs are tied to 0.
  - The amb_total register and the output count registers are not built.
  - The accumulators remain, because the decision rule needs them.
  - decision_o, ambiguous_o and result_valid_o are unchanged.

## Test plan
Parameters N=10, HI_THRESH=8, LO_THRESH=2, WINDOW=4 unless noted.
- Reset: hold reset_n=0 for 3 cycles with valid_i=1 and bundle 0x3FF -> all outputs 0 and no strobe until 3 cycles after the 4th post-reset accept.
- All-ones: 4 consecutive samples of 0x3FF -> strobe 3 cycles after the 4th accept; decision_o=1, ambiguous_o=0, ones_cnt_o=4.
- Low side: samples 0x000, 0x001, 0x003, 0x000 -> decision_o=0 and zeros_cnt_o=4 (popcount 2 still counts as ZERO).
- Mid-band: following a decision of 1, 4 samples of 0x01F (popcount 5) -> ambiguous_o=1, decision_o stays 1, undef_cnt_o=4, amb_total_o=4. Repeat 16384 windows -> amb_total_o=0xFFFF.
- Bubbles and boundary: 8 samples of 0x3FF with idle cycles between them, then continuous valid -> exactly two strobes, each 3 cycles after the 4th and 8th accepts. A sample arriving during REPORT counts toward the next window.
- Clear: 2 samples of 0x000, then clear_i together with a valid sample, then 4 samples of 0x3FF -> one strobe only, with decision_o=1 and ones_cnt_o=4. With DECODER_STATS_EN undefined, the same stimulus gives identical decision and strobe timing and zero counts.
